// File: rtl/register_bus_reader_if.sv
// Handshake and bus signals between the register-bus read master and its environment.
// Request/response are valid/ready; cs is the active-low per-register select onto the shared bus.
interface register_bus_reader_if #(
  parameter int NrOfBits = 8,
  parameter int NrOfRegs = 4
);
  localparam int IdxBits = (NrOfRegs > 1) ? $clog2(NrOfRegs) : 1;

  logic                req_valid;
  logic [IdxBits-1:0]  req_idx;
  logic                req_ready;
  logic [NrOfRegs-1:0] cs;
  logic [NrOfBits-1:0] bus_in;
  logic                rd_valid;
  logic                rd_ready;
  logic [NrOfBits-1:0] rd_data;
  logic [IdxBits-1:0]  rd_idx;
  logic                rd_err;
  logic                busy;

  modport master (
    input  req_valid, req_idx, bus_in, rd_ready,
    output req_ready, cs, rd_valid, rd_data, rd_idx, rd_err, busy
  );

  modport slave (
    output req_valid, req_idx, bus_in, rd_ready,
    input  req_ready, cs, rd_valid, rd_data, rd_idx, rd_err, busy
  );
endinterface

// File: rtl/register_bus_reader.sv
// Read master for a shared tri-state register bus: select one register, settle, capture, turn around, respond.
// Latency SettleCycles+TurnCycles Tick-cycles; response held until rd_ready, no request accepted meanwhile.
module register_bus_reader #(
  parameter int NrOfBits     = 8,
  parameter int NrOfRegs     = 4,
  parameter int SettleCycles = 2,
  parameter int TurnCycles   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  register_bus_reader_if.master rb
);
  localparam int IdxBits = (NrOfRegs > 1) ? $clog2(NrOfRegs) : 1;
  localparam int MaxCnt  = (SettleCycles > TurnCycles) ? SettleCycles : TurnCycles;
  localparam int CntBits = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntBits-1:0] SettleLoad = CntBits'(SettleCycles - 1);
  localparam logic [CntBits-1:0] TurnLoad   = (TurnCycles > 0) ? CntBits'(TurnCycles - 1) : '0;
  localparam logic [IdxBits:0]   RegsLimit  = (IdxBits + 1)'(NrOfRegs);

  typedef enum logic [1:0] {IDLE, SEL, TURN, OUT} state_t;

  state_t              state;
  logic [CntBits-1:0]  counter;
  logic [NrOfRegs-1:0] cs_q;
  logic                rd_valid_q;
  logic [NrOfBits-1:0] rd_data_q;
  logic [IdxBits-1:0]  rd_idx_q;
  logic                rd_err_q;

  logic [NrOfRegs-1:0] cs_sel;
  logic                idx_ok;

  always_comb begin
    cs_sel = '1;
    for (int i = 0; i < NrOfRegs; i++) begin
      if (rb.req_idx == IdxBits'(i)) cs_sel[i] = 1'b0;
    end
  end

  assign idx_ok = ({1'b0, rb.req_idx} < RegsLimit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      cs_q       <= '1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rb.req_valid) begin
            rd_idx_q <= rb.req_idx;
            if (idx_ok) begin
              cs_q    <= cs_sel;
              counter <= SettleLoad;
              state   <= SEL;
            end else begin
              // Out-of-range index: answer immediately, never touch the bus.
              rd_data_q  <= '0;
              rd_err_q   <= 1'b1;
              rd_valid_q <= 1'b1;
              state      <= OUT;
            end
          end
        end
        SEL: begin
          if (tick) begin
            if (counter == '0) begin
              rd_data_q <= rb.bus_in;
              rd_err_q  <= 1'b0;
              cs_q      <= '1;
              if (TurnCycles == 0) begin
                rd_valid_q <= 1'b1;
                state      <= OUT;
              end else begin
                counter <= TurnLoad;
                state   <= TURN;
              end
            end else begin
              counter <= counter - 1'b1;
            end
          end
        end
        TURN: begin
          // All selects released so the previous driver has let go before the next read.
          if (tick) begin
            if (counter == '0) begin
              rd_valid_q <= 1'b1;
              state      <= OUT;
            end else begin
              counter <= counter - 1'b1;
            end
          end
        end
        OUT: begin
          if (rb.rd_ready) begin
            rd_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          cs_q  <= '1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign rb.req_ready = (state == IDLE);
  assign rb.busy      = (state != IDLE);
  assign rb.cs        = cs_q;
  assign rb.rd_valid  = rd_valid_q;
  assign rb.rd_data   = rd_data_q;
  assign rb.rd_idx    = rd_idx_q;
  assign rb.rd_err    = rd_err_q;
endmodule

// File: tb/tb_register_bus_reader.sv
// Directed bench: a 4-register bus with default timing plus a 3-register instance for out-of-range reads.
module tb_register_bus_reader;
  logic clk;
  logic rst_n;
  logic tick;
  int   total;
  int   passed;

  register_bus_reader_if #(.NrOfBits(8), .NrOfRegs(4)) bif ();
  register_bus_reader_if #(.NrOfBits(8), .NrOfRegs(3)) bif3 ();

  register_bus_reader #(.NrOfBits(8), .NrOfRegs(4), .SettleCycles(2), .TurnCycles(1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rb(bif)
  );

  register_bus_reader #(.NrOfBits(8), .NrOfRegs(3), .SettleCycles(2), .TurnCycles(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rb(bif3)
  );

  always #5 clk = ~clk;

  // Register model: each register drives only while its select is low.
  logic [7:0] bus_val;
  always_comb begin
    bus_val = 8'h00;
    if (!bif.cs[0]) bus_val = 8'h3C;
    if (!bif.cs[1]) bus_val = 8'h5A;
    if (!bif.cs[2]) bus_val = 8'hA5;
    if (!bif.cs[3]) bus_val = 8'hC3;
  end
  assign bif.bus_in = bus_val;

  typedef struct {
    logic [1:0] idx;
    int         period;
    int         stall;
    logic [7:0] data;
    int         cs_low;
    int         lat;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_read(input vec_t v, input string tag);
    int         cs_low;
    int         lat;
    logic [3:0] exp_cs;
    cs_low = 0;
    lat    = -1;
    exp_cs = 4'b1111;
    exp_cs[v.idx] = 1'b0;
    chk({tag, "_req_ready_idle"}, 32'(bif.req_ready), 32'd1);
    bif.req_valid = 1'b1;
    bif.req_idx   = v.idx;
    tick          = (v.period == 1);
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    bif.req_idx   = ~v.idx;
    for (int k = 0; k < 60; k++) begin
      if (bif.rd_valid) begin
        lat = k;
        break;
      end
      if (bif.cs != 4'b1111) begin
        cs_low++;
        chk({tag, "_cs_pattern"}, 32'(bif.cs), 32'(exp_cs));
      end
      tick = ((k % v.period) == (v.period - 1));
      @(posedge clk); #1;
    end
    tick = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
    chk({tag, "_cs_low_cycles"}, 32'(cs_low), 32'(v.cs_low));
    chk({tag, "_rd_data"}, 32'(bif.rd_data), 32'(v.data));
    chk({tag, "_rd_idx"}, 32'(bif.rd_idx), 32'(v.idx));
    chk({tag, "_rd_err"}, 32'(bif.rd_err), 32'd0);
    chk({tag, "_cs_released"}, 32'(bif.cs), 32'hF);
    for (int s = 0; s < v.stall; s++) begin
      chk({tag, "_stall_req_ready"}, 32'(bif.req_ready), 32'd0);
      chk({tag, "_stall_rd_valid"}, 32'(bif.rd_valid), 32'd1);
      chk({tag, "_stall_rd_data"}, 32'(bif.rd_data), 32'(v.data));
      chk({tag, "_stall_rd_idx"}, 32'(bif.rd_idx), 32'(v.idx));
      @(posedge clk); #1;
    end
    bif.rd_ready = 1'b1;
    @(posedge clk); #1;
    bif.rd_ready = 1'b0;
    chk({tag, "_done_rd_valid"}, 32'(bif.rd_valid), 32'd0);
    chk({tag, "_done_req_ready"}, 32'(bif.req_ready), 32'd1);
    chk({tag, "_done_busy"}, 32'(bif.busy), 32'd0);
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    tick  = 1'b0;
    total = 0;
    passed = 0;
    bif.req_valid  = 1'b1;
    bif.req_idx    = 2'd1;
    bif.rd_ready   = 1'b0;
    bif3.req_valid = 1'b0;
    bif3.req_idx   = 2'd0;
    bif3.rd_ready  = 1'b0;
    bif3.bus_in    = 8'hFF;

    //           idx   period stall data   cs_low lat
    vecs[0] = '{2'd2, 1,     0,    8'hA5, 2,     3};
    vecs[1] = '{2'd2, 3,     0,    8'hA5, 6,     9};
    vecs[2] = '{2'd1, 1,     5,    8'h5A, 2,     3};
    vecs[3] = '{2'd0, 1,     0,    8'h3C, 2,     3};
    vecs[4] = '{2'd3, 2,     2,    8'hC3, 4,     6};

    // Reset held with a request pending
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cs", 32'(bif.cs), 32'hF);
    chk("reset_rd_valid", 32'(bif.rd_valid), 32'd0);
    chk("reset_busy", 32'(bif.busy), 32'd0);
    bif.req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_req_ready", 32'(bif.req_ready), 32'd1);
    chk("post_reset_busy", 32'(bif.busy), 32'd0);
    chk("post_reset_rd_data", 32'(bif.rd_data), 32'd0);
    chk("post_reset_rd_idx", 32'(bif.rd_idx), 32'd0);
    chk("post_reset_cs3", 32'(bif3.cs), 32'h7);

    for (int i = 0; i < 5; i++) begin
      do_read(vecs[i], $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Reset while a read is selecting register 1
    bif.req_valid = 1'b1;
    bif.req_idx   = 2'd1;
    tick          = 1'b1;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    chk("sel_cs_before_reset", 32'(bif.cs), 32'hD);
    chk("sel_busy", 32'(bif.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_cs", 32'(bif.cs), 32'hF);
    chk("midreset_rd_valid", 32'(bif.rd_valid), 32'd0);
    chk("midreset_busy", 32'(bif.busy), 32'd0);
    rst_n = 1'b1;
    tick  = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midreset_no_response", 32'(bif.rd_valid), 32'd0);
    end
    do_read('{2'd0, 1, 0, 8'h3C, 2, 3}, "after_reset");

    // Out-of-range index on the 3-register instance
    bif3.req_valid = 1'b1;
    bif3.req_idx   = 2'd3;
    tick           = 1'b1;
    @(posedge clk); #1;
    bif3.req_valid = 1'b0;
    bif3.req_idx   = 2'd0;
    chk("oor_rd_valid", 32'(bif3.rd_valid), 32'd1);
    chk("oor_rd_err", 32'(bif3.rd_err), 32'd1);
    chk("oor_rd_data", 32'(bif3.rd_data), 32'd0);
    chk("oor_rd_idx", 32'(bif3.rd_idx), 32'd3);
    chk("oor_req_ready", 32'(bif3.req_ready), 32'd0);
    repeat (3) begin
      chk("oor_cs", 32'(bif3.cs), 32'h7);
      @(posedge clk); #1;
    end
    chk("oor_held_valid", 32'(bif3.rd_valid), 32'd1);
    bif3.rd_ready = 1'b1;
    @(posedge clk); #1;
    bif3.rd_ready = 1'b0;
    tick = 1'b0;
    chk("oor_done_rd_valid", 32'(bif3.rd_valid), 32'd0);
    chk("oor_done_req_ready", 32'(bif3.req_ready), 32'd1);
    chk("oor_done_cs", 32'(bif3.cs), 32'h7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
